minutes_counter: RTL

//   Timebase stage directly upstream of the hours counter. Divides the 1 kHz clkMSec

---
 rtl/clock_pkg.sv | 9 +
 rtl/mod_n_counter.sv | 50 +++++
 rtl/minutes_counter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared timebase constants and types for the minutes and hours stages.
package clock_pkg;

    localparam int SEC_PER_MIN  = 60;
    localparam int MIN_PER_HOUR = 60;

    typedef logic [5:0] sixty_t;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up-counter with clear priority, used for seconds and minutes.
// BCD_OUT_EN adds a next-value port so BCD copies can track on the same edge.
module mod_n_counter
    import clock_pkg::*;
#(
    parameter int N = 60
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   en_i,
    input  logic   clr_i,
    input  logic   inc_i,
    output sixty_t value_o,
`ifdef BCD_OUT_EN
    output sixty_t next_o,
`endif
    output logic   wrap_o
);

    sixty_t value_q, value_d;
    logic   step;
    logic   at_top;

    assign step   = en_i && inc_i;
    assign at_top = (value_q == sixty_t'(N - 1));
    assign wrap_o = step && !clr_i && at_top;

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (step) begin
            value_d = at_top ? '0 : value_q + 6'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
`ifdef BCD_OUT_EN
    assign next_o = value_d;
`endif

endmodule

// File: rtl/minutes_counter.sv
// Seconds/minutes timebase feeding the hours stage with hourInc.
// BCD_OUT_EN adds registered BCD digit outputs for seconds and minutes.
module minutes_counter
    import clock_pkg::*;
#(
    parameter int MS_PER_SEC = 1000
) (
    input  logic       clkMSec,
    input  logic       reset,
    input  logic       run,
    input  logic       incMin,
    input  logic       clrSec,
    output logic [5:0] second,
    output logic [5:0] minute,
`ifdef BCD_OUT_EN
    output logic [3:0] secOnes,
    output logic [2:0] secTens,
    output logic [3:0] minOnes,
    output logic [2:0] minTens,
`endif
    output logic       secTick,
    output logic       hourInc
);

    localparam int MSW = $clog2(MS_PER_SEC);

    logic [MSW-1:0] ms_q, ms_d;
    logic           ms_wrap;
    logic           sec_wrap;
    logic           min_wrap;
    logic           tick_q, tick_d;
    logic           hour_q, hour_d;
    sixty_t         sec_val, min_val;

    assign ms_wrap = run && (ms_q == MSW'(MS_PER_SEC - 1));

    always_comb begin
        ms_d = ms_q;
        if (clrSec) begin
            ms_d = '0;
        end else if (run) begin
            ms_d = ms_wrap ? '0 : ms_q + MSW'(1);
        end
    end

    // sec_wrap already excludes clrSec, so a cleared wrap never carries
    assign tick_d = ms_wrap && !clrSec;
    assign hour_d = sec_wrap && min_wrap;

    always_ff @(posedge clkMSec) begin
        if (reset) begin
            ms_q   <= '0;
            tick_q <= 1'b0;
            hour_q <= 1'b0;
        end else begin
            ms_q   <= ms_d;
            tick_q <= tick_d;
            hour_q <= hour_d;
        end
    end

`ifdef BCD_OUT_EN
    sixty_t sec_next, min_next;
`endif

    mod_n_counter #(.N(SEC_PER_MIN)) u_sec (
        .clk_i   (clkMSec),
        .rst_i   (reset),
        .en_i    (run),
        .clr_i   (clrSec),
        .inc_i   (ms_wrap),
        .value_o (sec_val),
`ifdef BCD_OUT_EN
        .next_o  (sec_next),
`endif
        .wrap_o  (sec_wrap)
    );

    // incMin and a natural carry on the same edge still advance by one
    mod_n_counter #(.N(MIN_PER_HOUR)) u_min (
        .clk_i   (clkMSec),
        .rst_i   (reset),
        .en_i    (1'b1),
        .clr_i   (1'b0),
        .inc_i   (sec_wrap || incMin),
        .value_o (min_val),
`ifdef BCD_OUT_EN
        .next_o  (min_next),
`endif
        .wrap_o  (min_wrap)
    );

    assign second  = sec_val;
    assign minute  = min_val;
    assign secTick = tick_q;
    assign hourInc = hour_q;

`ifdef BCD_OUT_EN
    function automatic logic [6:0] bcd_split(input sixty_t v);
        sixty_t t;
        sixty_t o;
        t = v / 6'd10;
        o = v - t * 6'd10;
        return {t[2:0], o[3:0]};
    endfunction

    logic [6:0] sec_bcd_q, min_bcd_q;

    always_ff @(posedge clkMSec) begin
        if (reset) begin
            sec_bcd_q <= '0;
            min_bcd_q <= '0;
        end else begin
            sec_bcd_q <= bcd_split(sec_next);
            min_bcd_q <= bcd_split(min_next);
        end
    end

    assign secOnes = sec_bcd_q[3:0];
    assign secTens = sec_bcd_q[6:4];
    assign minOnes = min_bcd_q[3:0];
    assign minTens = min_bcd_q[6:4];
`endif

endmodule
